// File: rtl/opti_result_buffer_pkg.sv
// Shared widths, FSM encodings, dump beat payload and helpers for the result buffer.
package opti_result_buffer_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DUMP    = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // One readback beat: sample, its index and the end-of-block marker.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } dump_beat_t;

  // Magnitude of a two's complement sample; the most negative code saturates to max positive.
  function automatic logic [DATA_W-1:0] abs_sat(input logic [DATA_W-1:0] x);
    if (x == {1'b1, {(DATA_W-1){1'b0}}}) begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end else if (x[DATA_W-1]) begin
      return DATA_W'(~x + 1'b1);
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/opti_sample_ram.sv
// Simple dual-port sample RAM: one write port, one synchronous read port, no array reset.
// Ports: clk; i_wr_en/i_wr_addr/i_wr_data write port; i_rd_en/i_rd_addr read request;
//        o_rd_data read data, valid the cycle after i_rd_en.
module opti_sample_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Plain write-port / registered-read template so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      o_rd_data <= r_mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/opti_result_buffer.sv
// Output capture stage: stores filtered samples in RAM, tracks count/peak/overflow and
// streams the captured block back over a valid/ready interface.
// Ports: clk, rst (sync, active-high); start arms capture in IDLE/DONE;
//        cap_valid/cap_data/cap_done from the IIR pipeline;
//        dump_valid/dump_data/dump_addr/dump_last with dump_ready for readback;
//        busy, buf_done status; sample_cnt, peak_abs, overflow capture statistics.
module opti_result_buffer
  import opti_result_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cap_valid,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              cap_done,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_last,
  output logic              busy,
  output logic              buf_done,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [DATA_W-1:0] peak_abs,
  output logic              overflow
);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              r_busy;
  logic              r_buf_done;

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic              r_rd_all;
  logic [CNT_W-1:0]  r_sample_cnt;
  logic [DATA_W-1:0] r_peak;
  logic              r_overflow;

  logic              r_pend;
  logic [ADDR_W-1:0] r_pend_addr;
  logic              r_pend_last;
  dump_beat_t        r_out;
  logic              r_out_vld;
  dump_beat_t        r_skid;
  logic              r_skid_vld;

  logic              w_full;
  logic              w_start_acc;
  logic              w_wr_en;
  logic              w_pop;
  logic              w_out_free;
  logic              w_rd_last;
  logic              w_rd_en;
  logic [1:0]        w_occ_next;
  logic [DATA_W-1:0] w_abs;
  logic [DATA_W-1:0] w_rd_data;
  dump_beat_t        w_arrive;

  assign w_full      = (r_sample_cnt == CNT_W'(DEPTH));
  assign w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_wr_en     = (r_state == ST_CAPTURE) && cap_valid && !w_full;
  assign w_abs       = abs_sat(cap_data);

  assign w_pop       = r_out_vld && dump_ready;
  assign w_out_free  = !r_out_vld || w_pop;
  assign w_rd_last   = ({1'b0, r_rd_ptr} == (r_sample_cnt - CNT_W'(1)));

  // Beats held after this cycle (output + skid + arriving read, minus the one leaving);
  // a new read is only issued when its data is guaranteed a slot next cycle.
  assign w_occ_next  = 2'(r_out_vld) + 2'(r_skid_vld) + 2'(r_pend) - 2'(w_pop);
  assign w_rd_en     = (r_state == ST_DUMP) && !r_rd_all && (w_occ_next <= 2'd1);

  assign w_arrive.data = w_rd_data;
  assign w_arrive.addr = r_pend_addr;
  assign w_arrive.last = r_pend_last;

  opti_sample_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (cap_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // A sample written in the closing cycle still makes the block non-empty.
        if (cap_done || w_full) begin
          w_next_state = ((r_sample_cnt != '0) || w_wr_en) ? ST_DUMP : ST_DONE;
        end
      end
      ST_DUMP: begin
        if (w_pop && r_out.last) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        if (start) w_next_state = ST_CAPTURE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register and registered status decodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_buf_done <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_busy     <= (w_next_state == ST_CAPTURE) || (w_next_state == ST_DUMP);
      r_buf_done <= (w_next_state == ST_DONE);
    end
  end

  // Capture pointers and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_rd_all     <= 1'b0;
      r_sample_cnt <= '0;
      r_peak       <= '0;
      r_overflow   <= 1'b0;
    end else if (w_start_acc) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_rd_all     <= 1'b0;
      r_sample_cnt <= '0;
      r_peak       <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr     <= r_wr_ptr + ADDR_W'(1);
        r_sample_cnt <= r_sample_cnt + CNT_W'(1);
        if (w_abs > r_peak) r_peak <= w_abs;
      end
      if ((r_state == ST_CAPTURE) && cap_valid && w_full) begin
        r_overflow <= 1'b1;
      end
      // Stop at the final index instead of incrementing past it.
      if (w_rd_en) begin
        if (w_rd_last) r_rd_all <= 1'b1;
        else           r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
    end
  end

  // Read pipeline: RAM data lands in the output register, or in the skid register when
  // the output is stalled, so continuous ready sustains one beat per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_pend_last <= 1'b0;
      r_out       <= '0;
      r_out_vld   <= 1'b0;
      r_skid      <= '0;
      r_skid_vld  <= 1'b0;
    end else begin
      r_pend      <= w_rd_en;
      r_pend_addr <= r_rd_ptr;
      r_pend_last <= w_rd_last;
      if (w_out_free) begin
        if (r_skid_vld) begin
          r_out      <= r_skid;
          r_out_vld  <= 1'b1;
          r_skid_vld <= r_pend;
          if (r_pend) r_skid <= w_arrive;
        end else begin
          r_out_vld <= r_pend;
          if (r_pend) r_out <= w_arrive;
        end
      end else if (r_pend) begin
        r_skid     <= w_arrive;
        r_skid_vld <= 1'b1;
      end
    end
  end

  assign dump_valid = r_out_vld;
  assign dump_data  = r_out.data;
  assign dump_addr  = r_out.addr;
  assign dump_last  = r_out.last;
  assign busy       = r_busy;
  assign buf_done   = r_buf_done;
  assign sample_cnt = r_sample_cnt;
  assign peak_abs   = r_peak;
  assign overflow   = r_overflow;

endmodule
